// File: rtl/otter_iobus_timer.sv
// Machine-timer responder on the Otter external IO bus.
// Holds the 64-bit mtime/mtimecmp pair and a control register (enable + prescale divisor).
// Raises MTIP on o_intrpt[7] whenever mtime >= mtimecmp.
// Define OTTER_TIMER_MSIP_EN to add a software-interrupt register at offset 0x14, driving o_intrpt[3].
module otter_iobus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
  parameter logic [31:0] CTRL_RST  = 32'h0000_0001,
  parameter int          PRESC_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_iobus_re,
  input  logic        i_iobus_we,
  input  logic [3:0]  i_iobus_sel,
  input  logic [31:0] i_iobus_addr,
  input  logic [31:0] i_iobus_wdata,
  output logic [31:0] o_iobus_rdata,
  output logic        o_iobus_ack,
  output logic [31:0] o_intrpt
);

  // Word offsets within the 256-byte window
  localparam logic [5:0] OFF_MTIME_LO    = 6'h00;
  localparam logic [5:0] OFF_MTIME_HI    = 6'h01;
  localparam logic [5:0] OFF_MTIMECMP_LO = 6'h02;
  localparam logic [5:0] OFF_MTIMECMP_HI = 6'h03;
  localparam logic [5:0] OFF_CTRL        = 6'h04;
`ifdef OTTER_TIMER_MSIP_EN
  localparam logic [5:0] OFF_MSIP        = 6'h05;
`endif

  // Only EN (bit0) and the divisor field of CTRL are storage; everything else reads 0
  localparam logic [31:0] CTRL_MASK = 32'h1 | (((32'h1 << PRESC_W) - 32'h1) << 8);
  localparam logic [PRESC_W-1:0] PRESC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

  logic [63:0]        r_mtime;
  logic [63:0]        r_mtimecmp;
  logic [31:0]        r_ctrl;
  logic [PRESC_W-1:0] r_presc;
  logic               r_mtip;
  logic               r_ack;
  logic [31:0]        r_rdata;

  logic               w_hit;
  logic [5:0]         w_off;
  logic               w_wr;
  logic               w_wrMtimeLo;
  logic               w_wrMtimeHi;
  logic               w_wrCmpLo;
  logic               w_wrCmpHi;
  logic               w_wrCtrl;
  logic               w_en;
  logic [PRESC_W-1:0] w_div;
  logic               w_tick;
  logic [31:0]        w_readData;
  logic               w_unused;

  // Replace only the byte lanes that are enabled by sel
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = oldVal;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = newVal[8*b +: 8];
    end
    return res;
  endfunction

  assign w_hit       = (i_iobus_re | i_iobus_we) && (i_iobus_addr[31:8] == BASE_ADDR[31:8]);
  assign w_off       = i_iobus_addr[7:2];
  assign w_wr        = w_hit && i_iobus_we;
  assign w_wrMtimeLo = w_wr && (w_off == OFF_MTIME_LO);
  assign w_wrMtimeHi = w_wr && (w_off == OFF_MTIME_HI);
  assign w_wrCmpLo   = w_wr && (w_off == OFF_MTIMECMP_LO);
  assign w_wrCmpHi   = w_wr && (w_off == OFF_MTIMECMP_HI);
  assign w_wrCtrl    = w_wr && (w_off == OFF_CTRL);
  assign w_en        = r_ctrl[0];
  assign w_div       = r_ctrl[8 +: PRESC_W];
  assign w_tick      = w_en && (r_presc == w_div);
  assign w_unused    = ^i_iobus_addr[1:0];

`ifdef OTTER_TIMER_MSIP_EN
  logic r_msip;
  logic w_wrMsip;
  assign w_wrMsip = w_wr && (w_off == OFF_MSIP);

  // Software interrupt pending bit; only lane 0 carries the writable bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         r_msip <= 1'b0;
    else if (w_wrMsip && i_iobus_sel[0]) r_msip <= i_iobus_wdata[0];
  end

  assign o_intrpt = {24'd0, r_mtip, 3'd0, r_msip, 3'd0};
`else
  assign o_intrpt = {24'd0, r_mtip, 7'd0};
`endif

  // Register read multiplexer; unmapped offsets read as zero
  always_comb begin
    w_readData = '0;
    case (w_off)
      OFF_MTIME_LO:    w_readData = r_mtime[31:0];
      OFF_MTIME_HI:    w_readData = r_mtime[63:32];
      OFF_MTIMECMP_LO: w_readData = r_mtimecmp[31:0];
      OFF_MTIMECMP_HI: w_readData = r_mtimecmp[63:32];
      OFF_CTRL:        w_readData = r_ctrl;
`ifdef OTTER_TIMER_MSIP_EN
      OFF_MSIP:        w_readData = {31'd0, r_msip};
`endif
      default:         w_readData = '0;
    endcase
  end

  // Bus response: one registered ack per hit, read data returns the pre-write value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_hit;
      r_rdata <= (w_hit && i_iobus_re) ? w_readData : '0;
    end
  end

  assign o_iobus_ack   = r_ack;
  assign o_iobus_rdata = r_rdata;

  // Control register; writing it also restarts the prescaler
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_ctrl <= CTRL_RST & CTRL_MASK;
    else if (w_wrCtrl) r_ctrl <= mergeBytes(r_ctrl, i_iobus_wdata, i_iobus_sel) & CTRL_MASK;
  end

  // Prescaler: counts 0..DIV while enabled, wrapping on each mtime tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_presc <= '0;
    else if (w_wrCtrl) r_presc <= '0;
    else if (w_en)     r_presc <= w_tick ? '0 : r_presc + PRESC_ONE;
  end

  // mtime: a software write to either word beats the tick and blocks any carry that edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_mtime <= '0;
    else if (w_wrMtimeLo) r_mtime[31:0]  <= mergeBytes(r_mtime[31:0], i_iobus_wdata, i_iobus_sel);
    else if (w_wrMtimeHi) r_mtime[63:32] <= mergeBytes(r_mtime[63:32], i_iobus_wdata, i_iobus_sel);
    else if (w_tick)      r_mtime <= r_mtime + 64'd1;
  end

  // mtimecmp: plain byte-lane writable storage, resets to the maximum so MTIP starts low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_mtimecmp <= '1;
    else if (w_wrCmpLo) r_mtimecmp[31:0]  <= mergeBytes(r_mtimecmp[31:0], i_iobus_wdata, i_iobus_sel);
    else if (w_wrCmpHi) r_mtimecmp[63:32] <= mergeBytes(r_mtimecmp[63:32], i_iobus_wdata, i_iobus_sel);
  end

  // MTIP is a registered level from the current register values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_mtip <= 1'b0;
    else      r_mtip <= (r_mtime >= r_mtimecmp);
  end

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Self-checking bench for otter_iobus_timer: reads go through a scoreboard queue of expected data.
// Exercises the MSIP register when OTTER_TIMER_MSIP_EN is defined, otherwise checks 0x14 is unmapped.
module tb_otter_iobus_timer;

  localparam logic [31:0] BASE    = 32'h1100_0000;
  localparam logic [31:0] A_LO    = BASE + 32'h00;
  localparam logic [31:0] A_HI    = BASE + 32'h04;
  localparam logic [31:0] A_CLO   = BASE + 32'h08;
  localparam logic [31:0] A_CHI   = BASE + 32'h0C;
  localparam logic [31:0] A_CTRL  = BASE + 32'h10;
  localparam logic [31:0] A_MSIP  = BASE + 32'h14;
  localparam logic [31:0] A_UNMAP = BASE + 32'h18;
  localparam logic [31:0] A_MISS  = 32'h1200_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_iobus_re = 1'b0;
  logic        i_iobus_we = 1'b0;
  logic [3:0]  i_iobus_sel = 4'h0;
  logic [31:0] i_iobus_addr = '0;
  logic [31:0] i_iobus_wdata = '0;
  logic [31:0] o_iobus_rdata;
  logic        o_iobus_ack;
  logic [31:0] o_intrpt;

  int          passCount = 0;
  int          checkCount = 0;
  logic [31:0] expQ[$];
  logic [31:0] expVal;

  otter_iobus_timer dut (
    .clk           (clk),
    .rst           (rst),
    .i_iobus_re    (i_iobus_re),
    .i_iobus_we    (i_iobus_we),
    .i_iobus_sel   (i_iobus_sel),
    .i_iobus_addr  (i_iobus_addr),
    .i_iobus_wdata (i_iobus_wdata),
    .o_iobus_rdata (o_iobus_rdata),
    .o_iobus_ack   (o_iobus_ack),
    .o_intrpt      (o_intrpt)
  );

  always #5 clk = ~clk;

  // Drives one request so it is sampled at the next rising edge; returns 1ns after that edge
  task automatic busReq(input logic re, input logic we, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    i_iobus_re    = re;
    i_iobus_we    = we;
    i_iobus_sel   = sel;
    i_iobus_addr  = addr;
    i_iobus_wdata = wdata;
    @(posedge clk);
    #1;
    i_iobus_re  = 1'b0;
    i_iobus_we  = 1'b0;
    i_iobus_sel = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #22;
    checkCount++; if (o_iobus_ack !== 1'b0) $display("[TB] FAIL rst_ack: got %b expected 0", o_iobus_ack); else passCount++;
    checkCount++; if (o_iobus_rdata !== 32'h0) $display("[TB] FAIL rst_rdata: got %h expected 0", o_iobus_rdata); else passCount++;
    checkCount++; if (o_intrpt !== 32'h0) $display("[TB] FAIL rst_intrpt: got %h expected 0", o_intrpt); else passCount++;
    @(negedge clk);
    rst = 1'b1;
    expQ.push_back(32'hFFFF_FFFF);
    busReq(1'b1, 1'b0, 4'h0, A_CLO, '0);
    expVal = expQ.pop_front();
    checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL rst_cmplo: got ack=%b data=%h expected ack=1 data=%h", o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    idle(1);
    checkCount++; if (o_iobus_ack !== 1'b0) $display("[TB] FAIL rst_ack_single: got %b expected 0", o_iobus_ack); else passCount++;
    expQ.push_back(32'hFFFF_FFFF);
    busReq(1'b1, 1'b0, 4'h0, A_CHI, '0);
    expVal = expQ.pop_front();
    checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL rst_cmphi: got ack=%b data=%h expected ack=1 data=%h", o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    expQ.push_back(32'h0000_0001);
    busReq(1'b1, 1'b0, 4'h0, A_CTRL, '0);
    expVal = expQ.pop_front();
    checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL rst_ctrl: got ack=%b data=%h expected ack=1 data=%h", o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    checkCount++; if (o_intrpt !== 32'h0) $display("[TB] FAIL rst_intrpt_after: got %h expected 0", o_intrpt); else passCount++;
  endtask

  task automatic test_counting;
    busReq(1'b0, 1'b1, 4'hF, A_CTRL, 32'h0);
    busReq(1'b0, 1'b1, 4'hF, A_LO, 32'h0);
    busReq(1'b0, 1'b1, 4'hF, A_HI, 32'h0);
    expQ.push_back(32'h0);
    busReq(1'b1, 1'b0, 4'h0, A_LO, '0);
    expVal = expQ.pop_front();
    checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL frozen_lo: got ack=%b data=%h expected ack=1 data=%h", o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    busReq(1'b0, 1'b1, 4'hF, A_CTRL, 32'h1);
    idle(10);
    for (int k = 0; k < 2; k++) begin
      expQ.push_back(32'd10 + k);
      busReq(1'b1, 1'b0, 4'h0, A_LO, '0);
      expVal = expQ.pop_front();
      checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL div0_read%0d: got ack=%b data=%h expected ack=1 data=%h", k, o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    end
    busReq(1'b0, 1'b1, 4'hF, A_CTRL, 32'h0);
    busReq(1'b0, 1'b1, 4'hF, A_LO, 32'h100);
    busReq(1'b0, 1'b1, 4'hF, A_CTRL, 32'h301);
    for (int k = 1; k <= 9; k++) begin
      expQ.push_back(32'h100 + ((k - 1) / 4));
      busReq(1'b1, 1'b0, 4'h0, A_LO, '0);
      expVal = expQ.pop_front();
      checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL div3_read%0d: got ack=%b data=%h expected ack=1 data=%h", k, o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    end
  endtask

  task automatic test_carry;
    logic [31:0] addrs[4];
    logic [31:0] exps[4];
    busReq(1'b0, 1'b1, 4'hF, A_CTRL, 32'h0);
    busReq(1'b0, 1'b1, 4'hF, A_LO, 32'hFFFF_FFFE);
    busReq(1'b0, 1'b1, 4'hF, A_HI, 32'h0);
    busReq(1'b0, 1'b1, 4'hF, A_CTRL, 32'h1);
    addrs = '{A_LO, A_LO, A_LO, A_HI};
    exps  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    for (int k = 0; k < 4; k++) begin
      expQ.push_back(exps[k]);
      busReq(1'b1, 1'b0, 4'h0, addrs[k], '0);
      expVal = expQ.pop_front();
      checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL carry_read%0d: got ack=%b data=%h expected ack=1 data=%h", k, o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    end
    busReq(1'b0, 1'b1, 4'hF, A_CTRL, 32'h0);
    busReq(1'b0, 1'b1, 4'hF, A_LO, 32'hFFFF_FFFF);
    busReq(1'b0, 1'b1, 4'hF, A_HI, 32'hFFFF_FFFF);
    busReq(1'b0, 1'b1, 4'hF, A_CTRL, 32'h1);
    addrs[0:2] = '{A_HI, A_LO, A_HI};
    exps[0:2]  = '{32'hFFFF_FFFF, 32'h0, 32'h0};
    for (int k = 0; k < 3; k++) begin
      expQ.push_back(exps[k]);
      busReq(1'b1, 1'b0, 4'h0, addrs[k], '0);
      expVal = expQ.pop_front();
      checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL wrap_read%0d: got ack=%b data=%h expected ack=1 data=%h", k, o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    end
  endtask

  task automatic test_mtip;
    busReq(1'b0, 1'b1, 4'hF, A_CTRL, 32'h0);
    busReq(1'b0, 1'b1, 4'hF, A_LO, 32'h3E);
    busReq(1'b0, 1'b1, 4'hF, A_HI, 32'h0);
    busReq(1'b0, 1'b1, 4'hF, A_CLO, 32'h40);
    busReq(1'b0, 1'b1, 4'hF, A_CHI, 32'h0);
    checkCount++; if (o_intrpt !== 32'h0) $display("[TB] FAIL mtip_armed: got %h expected 0", o_intrpt); else passCount++;
    busReq(1'b0, 1'b1, 4'hF, A_CTRL, 32'h1);
    idle(1);
    checkCount++; if (o_intrpt !== 32'h0) $display("[TB] FAIL mtip_at_3e: got %h expected 0", o_intrpt); else passCount++;
    idle(1);
    checkCount++; if (o_intrpt !== 32'h0) $display("[TB] FAIL mtip_at_3f: got %h expected 0", o_intrpt); else passCount++;
    idle(1);
    checkCount++; if (o_intrpt !== 32'h80) $display("[TB] FAIL mtip_rise: got %h expected 00000080", o_intrpt); else passCount++;
    busReq(1'b0, 1'b1, 4'hF, A_CHI, 32'h1);
    checkCount++; if (o_intrpt !== 32'h80) $display("[TB] FAIL mtip_lag: got %h expected 00000080", o_intrpt); else passCount++;
    idle(1);
    checkCount++; if (o_intrpt !== 32'h0) $display("[TB] FAIL mtip_clear: got %h expected 0", o_intrpt); else passCount++;
  endtask

  task automatic test_byte_lanes;
    busReq(1'b0, 1'b1, 4'hF, A_CTRL, 32'h0);
    busReq(1'b0, 1'b1, 4'hF, A_LO, 32'h1122_3344);
    busReq(1'b0, 1'b1, 4'hF, A_HI, 32'h0);
    busReq(1'b0, 1'b1, 4'hF, A_CTRL, 32'h1);
    busReq(1'b0, 1'b1, 4'b0010, A_LO, 32'hAABB_CCDD);
    expQ.push_back(32'h1122_CC44);
    busReq(1'b1, 1'b0, 4'h0, A_LO, '0);
    expVal = expQ.pop_front();
    checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL lane1_write: got ack=%b data=%h expected ack=1 data=%h", o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    expQ.push_back(32'h1122_CC45);
    busReq(1'b1, 1'b0, 4'h0, A_LO, '0);
    expVal = expQ.pop_front();
    checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL lane_resume: got ack=%b data=%h expected ack=1 data=%h", o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    expQ.push_back(32'h1122_CC46);
    busReq(1'b1, 1'b1, 4'hF, A_LO, 32'h5);
    expVal = expQ.pop_front();
    checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL rw_old_value: got ack=%b data=%h expected ack=1 data=%h", o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    idle(1);
    checkCount++; if (o_iobus_ack !== 1'b0) $display("[TB] FAIL rw_single_ack: got %b expected 0", o_iobus_ack); else passCount++;
    expQ.push_back(32'h6);
    busReq(1'b1, 1'b0, 4'h0, A_LO, '0);
    expVal = expQ.pop_front();
    checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL rw_applied: got ack=%b data=%h expected ack=1 data=%h", o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    busReq(1'b1, 1'b0, 4'h0, A_MISS, '0);
    checkCount++; if (o_iobus_ack !== 1'b0 || o_iobus_rdata !== 32'h0) $display("[TB] FAIL nonhit: got ack=%b data=%h expected ack=0 data=0", o_iobus_ack, o_iobus_rdata); else passCount++;
    expQ.push_back(32'h8);
    busReq(1'b1, 1'b0, 4'h0, A_LO, '0);
    expVal = expQ.pop_front();
    checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL lo_after_nonhit: got ack=%b data=%h expected ack=1 data=%h", o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    busReq(1'b1, 1'b0, 4'h0, A_UNMAP, '0);
    checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== 32'h0) $display("[TB] FAIL unmapped: got ack=%b data=%h expected ack=1 data=0", o_iobus_ack, o_iobus_rdata); else passCount++;
    expQ.push_back(32'h0);
    busReq(1'b1, 1'b0, 4'h0, A_HI, '0);
    expVal = expQ.pop_front();
    checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL hi_no_carry: got ack=%b data=%h expected ack=1 data=%h", o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    busReq(1'b0, 1'b1, 4'hF, A_CTRL, 32'hFFFF_FFFF);
    expQ.push_back(32'h0000_FF01);
    busReq(1'b1, 1'b0, 4'h0, A_CTRL, '0);
    expVal = expQ.pop_front();
    checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL ctrl_mask: got ack=%b data=%h expected ack=1 data=%h", o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    busReq(1'b0, 1'b1, 4'hF, A_CTRL, 32'h1);
  endtask

  task automatic test_msip;
    expQ.push_back(32'h1);
    busReq(1'b1, 1'b0, 4'h0, A_CTRL, '0);
    expVal = expQ.pop_front();
    checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL msip_pre_ctrl: got ack=%b data=%h expected ack=1 data=%h", o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    busReq(1'b0, 1'b1, 4'hF, A_MSIP, 32'h1);
`ifdef OTTER_TIMER_MSIP_EN
    checkCount++; if (o_intrpt !== 32'h8) $display("[TB] FAIL msip_set: got %h expected 00000008", o_intrpt); else passCount++;
    expQ.push_back(32'h1);
    busReq(1'b1, 1'b0, 4'h0, A_MSIP, '0);
    expVal = expQ.pop_front();
    checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL msip_read: got ack=%b data=%h expected ack=1 data=%h", o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    busReq(1'b0, 1'b1, 4'hF, A_MSIP, 32'h0);
    checkCount++; if (o_intrpt !== 32'h0) $display("[TB] FAIL msip_clear: got %h expected 0", o_intrpt); else passCount++;
`else
    checkCount++; if (o_intrpt !== 32'h0) $display("[TB] FAIL msip_absent_irq: got %h expected 0", o_intrpt); else passCount++;
    expQ.push_back(32'h0);
    busReq(1'b1, 1'b0, 4'h0, A_MSIP, '0);
    expVal = expQ.pop_front();
    checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL msip_absent_read: got ack=%b data=%h expected ack=1 data=%h", o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
`endif
  endtask

  task automatic test_async_reset;
    busReq(1'b0, 1'b1, 4'hF, A_CLO, 32'h0);
    busReq(1'b0, 1'b1, 4'hF, A_CHI, 32'h0);
    expQ.push_back(32'h1);
    busReq(1'b1, 1'b0, 4'h0, A_CTRL, '0);
    expVal = expQ.pop_front();
    checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL pre_reset_read: got ack=%b data=%h expected ack=1 data=%h", o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    checkCount++; if (o_intrpt !== 32'h80) $display("[TB] FAIL pre_reset_mtip: got %h expected 00000080", o_intrpt); else passCount++;
    #2;
    rst = 1'b0;
    #1;
    checkCount++; if (o_iobus_ack !== 1'b0 || o_iobus_rdata !== 32'h0 || o_intrpt !== 32'h0) $display("[TB] FAIL async_reset: got ack=%b data=%h intrpt=%h expected all 0", o_iobus_ack, o_iobus_rdata, o_intrpt); else passCount++;
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    expQ.push_back(32'hFFFF_FFFF);
    busReq(1'b1, 1'b0, 4'h0, A_CLO, '0);
    expVal = expQ.pop_front();
    checkCount++; if (o_iobus_ack !== 1'b1 || o_iobus_rdata !== expVal) $display("[TB] FAIL post_reset_cmp: got ack=%b data=%h expected ack=1 data=%h", o_iobus_ack, o_iobus_rdata, expVal); else passCount++;
    checkCount++; if (o_intrpt !== 32'h0) $display("[TB] FAIL post_reset_intrpt: got %h expected 0", o_intrpt); else passCount++;
  endtask

  initial begin
    test_reset();
    test_counting();
    test_carry();
    test_mtip();
    test_byte_lanes();
    test_msip();
    test_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
